nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_if.sv | 25 ++
 rtl/nibble_serial_adder.sv | 118 +++++++++++
 tb/tb_nibble_serial_adder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// Handshake and data bundle between a controller and nibble_serial_adder.
// The controller drives start/a/b/cin and observes busy/done/sum/cout.
// Transport only: no logic, no timing of its own.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder a+b+cin computed one nibble per clock through a single 4-bit adder.
// Latency: accept edge + WIDTH/4 edges to a valid result; done pulses one cycle later-decoded state.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped, not queued.

// 4-bit ripple adder slice: the only arithmetic in the serial datapath.
module parallel_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = 5'(a) + 5'(b) + 5'(cin);
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic [3:0]       s;
  logic             co;
  logic             last_nib;

  parallel_adder u_nib (
    .a   (opa[3:0]),
    .b   (opb[3:0]),
    .cin (cy),
    .s   (s),
    .co  (co)
  );

  // New nibble enters at the top so the LS nibble lands at bit 0 after NIB shifts.
  generate
    if (WIDTH == 4) begin : g_acc_single
      assign acc_next = s;
    end else begin : g_acc_shift
      assign acc_next = {s, acc[WIDTH-1:4]};
    end
  endgenerate

  assign last_nib = (cnt == CW'(NIB - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: accept in IDLE, run NIB nibble cycles, one DONE cycle, back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_nib)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, shift a nibble per RUN cycle, publish result on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            opa <= bus.a;
            opb <= bus.b;
            cy  <= bus.cin;
            cnt <= '0;
          end
        end
        RUN: begin
          opa <= opa >> 4;
          opb <= opb >> 4;
          acc <= acc_next;
          cy  <= co;
          cnt <= cnt + CW'(1);
          if (last_nib) begin
            sum_q  <= acc_next;
            cout_q <= co;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH 16 (directed), 4 and 32 (random vs a+b+cin).
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  logic rst_r_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder_if #(.WIDTH(16)) bus16();
  nibble_serial_adder_if #(.WIDTH(4))  bus4();
  nibble_serial_adder_if #(.WIDTH(32)) bus32();

  nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n),   .bus(bus16));
  nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_r_n), .bus(bus4));
  nibble_serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_r_n), .bus(bus32));

  typedef struct {
    logic [32:0] res;
    int          cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  exp_t q32[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: done seen with empty scoreboard", name);
  endtask

  // Monitors: pop on every done cycle; result and arrival cycle both checked.
  always @(negedge clk) begin
    if (bus16.done === 1'b1) begin
      if (q16.size() == 0) unexpected("w16 done");
      else begin
        exp_t e;
        e = q16.pop_front();
        check("w16 sum",  64'(bus16.sum),  64'(e.res[15:0]));
        check("w16 cout", 64'(bus16.cout), 64'(e.res[16]));
        check("w16 done cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (bus4.done === 1'b1) begin
      if (q4.size() == 0) unexpected("w4 done");
      else begin
        exp_t e;
        e = q4.pop_front();
        check("w4 sum",  64'(bus4.sum),  64'(e.res[3:0]));
        check("w4 cout", 64'(bus4.cout), 64'(e.res[4]));
        check("w4 done cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (bus32.done === 1'b1) begin
      if (q32.size() == 0) unexpected("w32 done");
      else begin
        exp_t e;
        e = q32.pop_front();
        check("w32 sum",  64'(bus32.sum),  64'(e.res[31:0]));
        check("w32 cout", 64'(bus32.cout), 64'(e.res[32]));
        check("w32 done cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // One 16-bit op from an idle negedge; returns at the next idle negedge.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [16:0] exp_res, input string name);
    int nbusy;
    exp_t e;
    nbusy = 0;
    bus16.start = 1'b1;
    bus16.a = a;
    bus16.b = b;
    bus16.cin = c;
    e.res = {16'b0, exp_res};
    e.cyc = cyc + 1 + 4;
    q16.push_back(e);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus16.start = 1'b0;
      bus16.a = ~a;
      bus16.b = ~b;
      bus16.cin = ~c;
      if (bus16.busy === 1'b1) nbusy++;
    end
    check({name, " busy cycles"}, 64'(nbusy), 64'd5);
    check({name, " sum held"}, 64'(bus16.sum), 64'(exp_res[15:0]));
  endtask

  task automatic run_directed;
    logic [15:0] va;
    logic [15:0] vb;
    exp_t e;
    op16(16'hFFFF, 16'h0001, 1'b0, 17'h1_0000, "ffff+1");
    op16(16'h1234, 16'h4321, 1'b1, 17'h0_5556, "cin inject");
    op16(16'h0FFF, 16'h0001, 1'b0, 17'h0_1000, "3-nibble carry");

    // start held high with operands changing every cycle: accepts at 0, 6, 12.
    for (int k = 0; k < 18; k++) begin
      va = 16'(k * 16'h0101 + 7);
      vb = 16'(k * 16'h2003);
      bus16.start = 1'b1;
      bus16.a = va;
      bus16.b = vb;
      bus16.cin = k[0];
      if (k % 6 == 0) begin
        e.res = 33'({1'b0, va} + {1'b0, vb} + 17'(k[0]));
        e.cyc = cyc + 1 + 4;
        q16.push_back(e);
      end
      @(negedge clk);
    end
    bus16.start = 1'b0;
    @(negedge clk);

    // Abort an operation two cycles after its accept.
    bus16.start = 1'b1;
    bus16.a = 16'h1111;
    bus16.b = 16'h2222;
    bus16.cin = 1'b0;
    @(negedge clk);
    bus16.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 64'(bus16.busy), 64'd0);
    check("abort done", 64'(bus16.done), 64'd0);
    check("abort sum",  64'(bus16.sum),  64'd0);
    check("abort cout", 64'(bus16.cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post-abort sum", 64'(bus16.sum), 64'd0);
    op16(16'h8000, 16'h8000, 1'b1, 17'h1_0001, "after abort");
  endtask

  task automatic run_rand4;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    exp_t e;
    repeat (1000) begin
      a = 4'($urandom);
      b = 4'($urandom);
      c = 1'($urandom);
      bus4.start = 1'b1;
      bus4.a = a;
      bus4.b = b;
      bus4.cin = c;
      e.res = 33'({1'b0, a} + {1'b0, b} + 5'(c));
      e.cyc = cyc + 1 + 1;
      q4.push_back(e);
      @(negedge clk);
      bus4.start = 1'b0;
      bus4.a = ~a;
      bus4.b = ~b;
      repeat (2) @(negedge clk);
      check("w4 sum stable", 64'(bus4.sum), 64'(e.res[3:0]));
    end
  endtask

  task automatic run_rand32;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    exp_t e;
    repeat (1000) begin
      a = $urandom;
      b = $urandom;
      c = 1'($urandom);
      bus32.start = 1'b1;
      bus32.a = a;
      bus32.b = b;
      bus32.cin = c;
      e.res = {1'b0, a} + {1'b0, b} + 33'(c);
      e.cyc = cyc + 1 + 8;
      q32.push_back(e);
      @(negedge clk);
      bus32.start = 1'b0;
      bus32.a = ~a;
      bus32.b = ~b;
      repeat (9) @(negedge clk);
      check("w32 sum stable", 64'(bus32.sum), 64'(e.res[31:0]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rst_r_n = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    bus4.start  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0;
    bus32.start = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0;
    #1;
    check("reset busy", 64'(bus16.busy), 64'd0);
    check("reset done", 64'(bus16.done), 64'd0);
    check("reset sum",  64'(bus16.sum),  64'd0);
    check("reset cout", 64'(bus16.cout), 64'd0);
    check("reset w32 sum", 64'(bus32.sum), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rst_r_n = 1'b1;
    fork
      run_directed();
      run_rand4();
      run_rand32();
    join
    repeat (5) @(negedge clk);
    check("w16 queue drained", 64'(q16.size()), 64'd0);
    check("w4 queue drained",  64'(q4.size()),  64'd0);
    check("w32 queue drained", 64'(q32.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
